// File: rtl/ft_checkpoint_mem_if.sv
// ---------------------------------------------------------------------------
// ft_checkpoint_mem_if
// Bus bundle for the checkpoint memory: the restore stream (checkpoint
// contents pushed back to the core) and the committed-data read port.
//
// Restore stream : rs_valid_o, rs_ready_i, rs_addr_o, rs_data_o, rs_pc_o
// Read port      : req_i, addr_i, gnt_o, rvalid_o, rdata_o, err_o
//
// The _i/_o suffixes are seen from the checkpoint memory.
// slave  : used by ft_checkpoint_mem.
// master : used by the core or the testbench.
// ---------------------------------------------------------------------------
interface ft_checkpoint_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RW         = 5
);
  logic                  rs_valid_o;
  logic                  rs_ready_i;
  logic [RW-1:0]         rs_addr_o;
  logic [DATA_WIDTH-1:0] rs_data_o;
  logic [DATA_WIDTH-1:0] rs_pc_o;

  logic                  req_i;
  logic [31:0]           addr_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport slave (
    input  rs_ready_i, req_i, addr_i,
    output rs_valid_o, rs_addr_o, rs_data_o, rs_pc_o,
    output gnt_o, rvalid_o, rdata_o, err_o
  );

  modport master (
    output rs_ready_i, req_i, addr_i,
    input  rs_valid_o, rs_addr_o, rs_data_o, rs_pc_o,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/ft_checkpoint_mem.sv
// ---------------------------------------------------------------------------
// ft_checkpoint_mem
// Checkpoint store for a core register file.
//
// The memory keeps a working copy W of the register file, which is written on
// every we_rf_i. A commit copies W into the committed bank C, one entry per
// cycle, and latches the PC. A restore streams C back to the core and also
// writes it into W. The read port only returns committed state.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   we_rf_i, addr_rf_i,
//   data_rf_i            register-file write mirror
//   pc_i                 core PC, captured on an accepted commit
//   commit_i, restore_i  single-cycle requests, only honoured in IDLE
//   busy_o               high while a copy or a restore is in progress
//   done_o               one-cycle pulse after a copy or restore ends
//   bus                  restore stream and read port (slave modport)
// ---------------------------------------------------------------------------
module ft_checkpoint_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int RW        = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_rf_i,
  input  logic [RW-1:0]         addr_rf_i,
  input  logic [DATA_WIDTH-1:0] data_rf_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  commit_i,
  input  logic                  restore_i,
  output logic                  busy_o,
  output logic                  done_o,
  ft_checkpoint_mem_if.slave    bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COPY    = 2'd1;
  localparam logic [1:0] S_RESTORE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [RW-1:0]         k_q, k_d;
  logic                  done_q, done_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] w_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] c_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] cpc_q;

  logic                  last_k_s;
  logic                  beat_s;
  logic                  commit_acc_s;
  logic                  gnt_s;
  logic [29:0]           idx_s;
  logic                  unused_s;

  // Byte address to word index. The byte offset bits carry no information.
  assign idx_s    = bus.addr_i[31:2];
  assign unused_s = ^bus.addr_i[1:0];

  assign last_k_s     = (k_q == RW'(NUM_REGS - 1));
  assign beat_s       = (state_q == S_RESTORE) && bus.rs_ready_i;
  // When both requests arrive together the restore wins and the commit is dropped.
  assign commit_acc_s = (state_q == S_IDLE) && commit_i && !restore_i;
  assign gnt_s        = bus.req_i && (state_q == S_IDLE);

  // Next-state logic: FSM, copy/restore index and end-of-operation pulse.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (restore_i) begin
          state_d = S_RESTORE;
          k_d     = '0;
        end else if (commit_i) begin
          state_d = S_COPY;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COPY: begin
        if (last_k_s) begin
          state_d = S_IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else begin
          k_d = k_q + RW'(1);
        end
      end
      S_RESTORE: begin
        if (beat_s && last_k_s) begin
          state_d = S_IDLE;
          k_d     = '0;
          done_d  = 1'b1;
        end else if (beat_s) begin
          k_d = k_q + RW'(1);
        end else begin
          k_d = k_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Read-port response, registered one cycle after the grant.
  always_comb begin
    rvalid_d = gnt_s;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (!gnt_s) begin
      rvalid_d = 1'b0;
    end else if (idx_s < 30'(NUM_REGS)) begin
      rdata_d = c_q[idx_s[RW-1:0]];
    end else if (idx_s == 30'(NUM_REGS)) begin
      rdata_d = cpc_q;
    end else begin
      err_d = 1'b1;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Working bank, committed bank and committed PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w_q[i] <= '0;
        c_q[i] <= '0;
      end
      cpc_q <= '0;
    end else begin
      if (we_rf_i) begin
        w_q[addr_rf_i] <= data_rf_i;
      end
      // Placed after the core write so that it wins on an index collision.
      if (beat_s) begin
        w_q[k_q] <= c_q[k_q];
      end
      // Forward a same-cycle write so the checkpoint sees the newest value.
      if (state_q == S_COPY) begin
        c_q[k_q] <= (we_rf_i && (addr_rf_i == k_q)) ? data_rf_i : w_q[k_q];
      end
      if (commit_acc_s) begin
        cpc_q <= pc_i;
      end
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign bus.rs_valid_o = (state_q == S_RESTORE);
  assign bus.rs_addr_o  = (state_q == S_RESTORE) ? k_q : '0;
  assign bus.rs_data_o  = (state_q == S_RESTORE) ? c_q[k_q] : '0;
  assign bus.rs_pc_o    = cpc_q;
  assign bus.gnt_o      = gnt_s;
  assign bus.rvalid_o   = rvalid_q;
  assign bus.rdata_o    = rdata_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_ft_checkpoint_mem.sv
// ---------------------------------------------------------------------------
// tb_ft_checkpoint_mem
// Directed testbench for ft_checkpoint_mem with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_ft_checkpoint_mem;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [RW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] pc;
  logic          commit;
  logic          restore;
  logic          busy;
  logic          done;

  ft_checkpoint_mem_if #(.DATA_WIDTH(DW), .RW(RW)) bus ();

  ft_checkpoint_mem #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_rf_i   (we),
    .addr_rf_i (waddr),
    .data_rf_i (wdata),
    .pc_i      (pc),
    .commit_i  (commit),
    .restore_i (restore),
    .busy_o    (busy),
    .done_o    (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_c [NR];
  logic [31:0] exp_cpc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [31:0] d);
    we    = 1'b1;
    waddr = i[RW-1:0];
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  task automatic commit_pc(input logic [31:0] p);
    commit = 1'b1;
    pc     = p;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
    logic g;
    bus.req_i  = 1'b1;
    bus.addr_i = a;
    #1;
    g = bus.gnt_o;
    tick();
    bus.req_i = 1'b0;
    check_eq({tag, "_gnt"}, {31'd0, g}, 32'd1);
    check_eq({tag, "_rvalid"}, {31'd0, bus.rvalid_o}, 32'd1);
    check_eq({tag, "_rdata"}, bus.rdata_o, exp_d);
    check_eq({tag, "_err"}, {31'd0, bus.err_o}, {31'd0, exp_e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bc;
    int  dc;
    int  e;
    bit  finished;

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; pc = '0;
    commit = 1'b0; restore = 1'b0;
    bus.rs_ready_i = 1'b0; bus.req_i = 1'b0; bus.addr_i = 32'd0;

    // Reset state
    tick();
    tick();
    check_eq("rst_busy",     {31'd0, busy}, 32'd0);
    check_eq("rst_done",     {31'd0, done}, 32'd0);
    check_eq("rst_rs_valid", {31'd0, bus.rs_valid_o}, 32'd0);
    check_eq("rst_rvalid",   {31'd0, bus.rvalid_o}, 32'd0);
    check_eq("rst_err",      {31'd0, bus.err_o}, 32'd0);
    check_eq("rst_rdata",    bus.rdata_o, 32'd0);
    check_eq("rst_rs_addr",  {27'd0, bus.rs_addr_o}, 32'd0);
    check_eq("rst_rs_data",  bus.rs_data_o, 32'd0);
    rst = 1'b0;
    tick();

    // Fill W, commit, and measure busy/done
    for (int i = 0; i < NR; i++) begin
      exp_c[i] = 32'h1000 + i;
      wr(i, exp_c[i]);
    end
    commit_pc(32'h80);
    exp_cpc = 32'h80;
    bc = 0;
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      if (busy) bc++;
      if (done) dc++;
      tick();
    end
    check_eq("copy_busy_cycles", bc, 32'd32);
    check_eq("copy_done_pulses", dc, 32'd1);
    for (int i = 0; i < NR; i++) rd_check("rd_c", i * 4, exp_c[i], 1'b0);
    rd_check("rd_cpc", 32'h80, exp_cpc, 1'b0);
    tick();
    check_eq("idle_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
    check_eq("idle_err",    {31'd0, bus.err_o}, 32'd0);

    // Write to the entry being copied (k = 5) is forwarded into C
    commit_pc(32'h90);
    repeat (5) tick();
    wr(5, 32'hDEAD);
    wait_idle(64);
    tick();
    exp_c[5] = 32'hDEAD;
    exp_cpc  = 32'h90;
    // Write at k = 5 to an entry already copied (index 3) does not reach C
    commit_pc(32'hA0);
    repeat (5) tick();
    wr(3, 32'hBEEF);
    wait_idle(64);
    tick();
    exp_cpc = 32'hA0;
    rd_check("fwd_c5", 32'd20, 32'hDEAD, 1'b0);
    rd_check("fwd_c3", 32'd12, 32'h1003, 1'b0);
    rd_check("fwd_c4", 32'd16, 32'h1004, 1'b0);
    rd_check("fwd_cpc", 32'h80, exp_cpc, 1'b0);

    // Commit and restore in the same cycle: restore wins, CPC is kept
    commit  = 1'b1;
    restore = 1'b1;
    pc      = 32'hBAD;
    tick();
    commit  = 1'b0;
    restore = 1'b0;
    check_eq("rs_busy", {31'd0, busy}, 32'd1);
    e = 0;
    finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      bus.rs_ready_i = c[0];
      bus.req_i      = (c == 3);
      #1;
      if (c == 3) check_eq("gnt_busy", {31'd0, bus.gnt_o}, 32'd0);
      if (c == 4) check_eq("rvalid_busy", {31'd0, bus.rvalid_o}, 32'd0);
      if (bus.rs_valid_o) begin
        check_eq("rs_addr", {27'd0, bus.rs_addr_o}, e);
        check_eq("rs_data", bus.rs_data_o, exp_c[e]);
        check_eq("rs_pc",   bus.rs_pc_o, exp_cpc);
        if (bus.rs_ready_i) e++;
        @(posedge clk);
        #1;
      end else begin
        check_eq("rs_done",  {31'd0, done}, 32'd1);
        check_eq("rs_beats", e, 32'd32);
        finished = 1'b1;
      end
    end
    check_eq("rs_timeout", {31'd0, finished}, 32'd1);
    bus.rs_ready_i = 1'b0;
    bus.req_i      = 1'b0;
    tick();
    check_eq("rs_done_once", {31'd0, done}, 32'd0);
    rd_check("rs_cpc_kept", 32'h80, 32'hA0, 1'b0);

    // Restore rewrote W from C, so a fresh commit reproduces C
    commit_pc(32'hC0);
    wait_idle(64);
    tick();
    exp_cpc = 32'hC0;
    rd_check("wc_c3",  32'd12, 32'h1003, 1'b0);
    rd_check("wc_c5",  32'd20, 32'hDEAD, 1'b0);
    rd_check("wc_c0",  32'd0,  32'h1000, 1'b0);
    rd_check("wc_c31", 32'd124, 32'h101F, 1'b0);
    rd_check("wc_cpc", 32'h80, exp_cpc, 1'b0);

    // Out-of-range reads and full upper-bit decode
    rd_check("oob_w33",   32'h84, 32'd0, 1'b1);
    rd_check("oob_w64",   32'h100, 32'd0, 1'b1);
    rd_check("alias_c0",  32'h8000_0000, 32'd0, 1'b1);
    rd_check("alias_cpc", 32'h8000_0080, 32'd0, 1'b1);
    tick();
    check_eq("oob_rvalid_clr", {31'd0, bus.rvalid_o}, 32'd0);
    check_eq("oob_err_clr",    {31'd0, bus.err_o}, 32'd0);

    // Reset at COPY k = 10 aborts and clears everything
    commit_pc(32'hD0);
    repeat (10) tick();
    check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_done", {31'd0, done}, 32'd0);
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dc++;
      tick();
    end
    check_eq("abort_no_done", dc, 32'd0);
    rd_check("abort_c0",  32'd0,   32'd0, 1'b0);
    rd_check("abort_c5",  32'd20,  32'd0, 1'b0);
    rd_check("abort_c10", 32'd40,  32'd0, 1'b0);
    rd_check("abort_c31", 32'd124, 32'd0, 1'b0);
    rd_check("abort_cpc", 32'h80,  32'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
